// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and default width.
package serial_subtractor_4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// One-bit full subtractor used by the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents diff/bout with a one-cycle done pulse after WIDTH shift cycles.
module serial_subtractor_4bit
    import serial_subtractor_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    // Only the upper WIDTH-1 result bits need storing; the final bit goes straight to diff.
    logic [WIDTH-2:0]   r_res;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;
    logic               w_accept;

    full_subtractor u_full_subtractor (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br_next)
    );

    assign w_res_next = {w_d, r_res};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

    // Controller, operand shifters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else if (w_accept) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
                ST_SHIFT: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_br  <= w_br_next;
                    r_res <= w_res_next[WIDTH-1:1];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
